// File: rtl/eth_pkg.sv
// Shared Ethernet receive-path definitions: framing bytes, CRC-32 constants,
// frame status codes and receive FSM states.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    // End-of-frame status, numeric values are visible on out_status.
    typedef enum logic [2:0] {
        RX_OK    = 3'd0,
        RX_FCS   = 3'd1,
        RX_SHORT = 3'd2,
        RX_LONG  = 3'd3,
        RX_RXER  = 3'd4
    } rx_status_e;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        PREAMBLE,
        DATA,
        DROP,
        DROP_LONG
    } rx_state_e;

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 (reflected, poly 0xEDB88320) next-state function,
// one byte per call. Shared between the RX and TX MACs.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h000000, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC32_POLY) : (r >> 1);
        end
        return r;
    endfunction

    assign crc_out = crc_step(crc_in, data);

endmodule

// File: rtl/gmii_rx_mac.sv
// GMII receive MAC front end: strips preamble/SFD, checks and strips the FCS,
// emits payload bytes with SOF and one end-of-frame status beat.
// Optional statistics counters are built when GMII_RX_STATS_EN is defined;
// otherwise the stat ports are tied to zero.
module gmii_rx_mac
    import eth_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int STAT_W  = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic [7:0]        gmii_rxd,
    input  logic              gmii_rx_dv,
    input  logic              gmii_rx_er,
    output logic [7:0]        out_data,
    output logic              out_valid,
    output logic              out_sof,
    output logic              out_eof,
    output logic [2:0]        out_status,
    output logic [STAT_W-1:0] stat_frames_ok,
    output logic [STAT_W-1:0] stat_frames_bad
);

    localparam logic [15:0] MIN_LEN_C = 16'(MIN_LEN);
    localparam logic [15:0] MAX_LEN_C = 16'(MAX_LEN);
    // Bytes held back in the delay line; that many trailing bytes are the FCS.
    localparam logic [15:0] FCS_LEN   = 16'd4;

    rx_state_e   state_q, state_d;
    logic [31:0] crc_q, crc_next;
    logic [15:0] cnt_q;
    logic        rxer_q;
    logic [7:0]  dl_q [4];

    logic        valid_d, sof_d, eof_d;
    logic [7:0]  data_d;
    rx_status_e  status_d;

    logic        sfd_seen, data_byte, long_hit, data_end, frame_tail, long_end;

    assign sfd_seen   = (state_q == PREAMBLE) && gmii_rx_dv && (gmii_rxd == ETH_SFD);
    assign data_byte  = (state_q == DATA) && gmii_rx_dv;
    assign long_hit   = data_byte && (cnt_q == MAX_LEN_C);
    assign data_end   = (state_q == DATA) && !gmii_rx_dv;
    // SOF was emitted exactly when more than the FCS length was received.
    assign frame_tail = data_end && (cnt_q > FCS_LEN);
    assign long_end   = (state_q == DROP_LONG) && !gmii_rx_dv;

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data    (gmii_rxd),
        .crc_out (crc_next)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge arst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!arst_n) state_q <= WAIT_IDLE;
        else         state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned
        // (which would infer a latch).
        state_d = state_q;
        case (state_q)
            WAIT_IDLE: if (!gmii_rx_dv) state_d = IDLE;
            IDLE: begin
                if (gmii_rx_dv) state_d = (gmii_rxd == ETH_PREAMBLE) ? PREAMBLE : DROP;
            end
            PREAMBLE: begin
                if (!gmii_rx_dv)                  state_d = IDLE;
                else if (gmii_rxd == ETH_SFD)      state_d = DATA;
                else if (gmii_rxd != ETH_PREAMBLE) state_d = DROP;
            end
            DATA: begin
                if (!gmii_rx_dv)   state_d = IDLE;
                else if (long_hit) state_d = DROP_LONG;
            end
            DROP:      if (!gmii_rx_dv) state_d = IDLE;
            DROP_LONG: if (!gmii_rx_dv) state_d = IDLE;
            default:   state_d = WAIT_IDLE;
        endcase
    end

    // FSM output logic: next values for the registered output beat.
    always_comb begin
        valid_d  = data_byte && !long_hit && (cnt_q >= FCS_LEN);
        sof_d    = valid_d && (cnt_q == FCS_LEN);
        data_d   = valid_d ? dl_q[3] : 8'h00;
        eof_d    = frame_tail || long_end;
        status_d = RX_OK;
        if (long_end) begin
            status_d = rxer_q ? RX_RXER : RX_LONG;
        end else if (frame_tail) begin
            if (rxer_q)                    status_d = RX_RXER;
            else if (cnt_q < MIN_LEN_C)    status_d = RX_SHORT;
            else if (crc_q != CRC32_RESIDUE) status_d = RX_FCS;
        end
    end

    // Per-frame CRC, saturating byte counter and latched rx_er.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            crc_q  <= CRC32_INIT;
            cnt_q  <= 16'd0;
            rxer_q <= 1'b0;
        end else if (sfd_seen) begin
            crc_q  <= CRC32_INIT;
            cnt_q  <= 16'd0;
            rxer_q <= 1'b0;
        end else if (data_byte) begin
            crc_q <= crc_next;
            if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
            if (gmii_rx_er)        rxer_q <= 1'b1;
        end
    end

    // Four-byte delay line that holds back the trailing FCS.
    always_ff @(posedge clk) begin
        // NOTE: no reset on this storage; its contents are only read once the
        // byte counter shows four fresh bytes have been shifted in.
        if (data_byte) begin
            dl_q[0] <= gmii_rxd;
            dl_q[1] <= dl_q[0];
            dl_q[2] <= dl_q[1];
            dl_q[3] <= dl_q[2];
        end
    end

    // Registered output beat.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            out_data   <= 8'h00;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            out_status <= 3'd0;
        end else begin
            out_data   <= data_d;
            out_valid  <= valid_d;
            out_sof    <= sof_d;
            out_eof    <= eof_d;
            out_status <= status_d;
        end
    end

`ifdef GMII_RX_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic drop_from_pre, inc_ok, inc_bad;

    assign drop_from_pre = (state_q == PREAMBLE) && gmii_rx_dv &&
                           (gmii_rxd != ETH_PREAMBLE) && (gmii_rxd != ETH_SFD);
    assign inc_ok  = eof_d && (status_d == RX_OK);
    assign inc_bad = (eof_d && (status_d != RX_OK)) || drop_from_pre ||
                     (data_end && (cnt_q <= FCS_LEN));

    // Saturating good/bad frame counters.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stat_frames_ok  <= '0;
            stat_frames_bad <= '0;
        end else begin
            if (inc_ok && (stat_frames_ok != STAT_MAX))   stat_frames_ok  <= stat_frames_ok + 1'b1;
            if (inc_bad && (stat_frames_bad != STAT_MAX)) stat_frames_bad <= stat_frames_bad + 1'b1;
        end
    end
`else
    assign stat_frames_ok  = '0;
    assign stat_frames_bad = '0;
`endif

endmodule

// File: tb/tb_gmii_rx_mac.sv
// Self-checking bench for gmii_rx_mac: table of frame vectors plus hand-written
// sequences for back-to-back frames, bad preamble and mid-frame reset.
module tb_gmii_rx_mac;
    import eth_pkg::*;

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;
    localparam int STAT_W  = 32;
`ifdef GMII_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              arst_n = 1'b0;
    logic [7:0]        gmii_rxd = 8'h00;
    logic              gmii_rx_dv = 1'b0;
    logic              gmii_rx_er = 1'b0;
    logic [7:0]        out_data;
    logic              out_valid, out_sof, out_eof;
    logic [2:0]        out_status;
    logic [STAT_W-1:0] stat_frames_ok, stat_frames_bad;

    gmii_rx_mac #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .STAT_W(STAT_W)) dut (
        .clk             (clk),
        .arst_n          (arst_n),
        .gmii_rxd        (gmii_rxd),
        .gmii_rx_dv      (gmii_rx_dv),
        .gmii_rx_er      (gmii_rx_er),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_sof         (out_sof),
        .out_eof         (out_eof),
        .out_status      (out_status),
        .stat_frames_ok  (stat_frames_ok),
        .stat_frames_bad (stat_frames_bad)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        bit         sof;
        bit         eof;
        logic [2:0] status;
    } beat_t;

    typedef struct {
        int         len;
        bit         good_fcs;
        bit         flip;
        int         rxer_at;
        int         exp_beats;
        bit         exp_eof;
        logic [2:0] exp_status;
    } vec_t;

    beat_t      exp_q[$];
    logic [7:0] fbuf [0:2047];
    int         total = 0, bad = 0;
    int         beat_cnt = 0, eof_cnt = 0, stray = 0;
    int         first_valid_cyc = 0, eof_cyc = 0, byte0_cyc = 0, dv_fall_cyc = 0;
    int         exp_ok = 0, exp_bad = 0;
    bit         sb_off = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Independent bit-serial CRC-32 for building FCS fields.
    function automatic logic [31:0] crc_bits(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int b = 0; b < 8; b++) begin
            fb = c[0] ^ d[b];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    task automatic build_frame(input int len, input bit good_fcs, input bit flip);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) fbuf[i] = 8'($urandom_range(0, 255));
        if (good_fcs && len >= 4) begin
            for (int i = 0; i < len - 4; i++) c = crc_bits(c, fbuf[i]);
            c = ~c;
            for (int k = 0; k < 4; k++) fbuf[len - 4 + k] = c[8*k +: 8];
        end
        if (flip) fbuf[len - 1] = fbuf[len - 1] ^ 8'h01;
    endtask

    task automatic drive(input logic dv, input logic er, input logic [7:0] d);
        @(posedge clk);
        #1;
        gmii_rx_dv = dv;
        gmii_rx_er = er;
        gmii_rxd   = d;
    endtask

    // Sends preamble, SFD, fbuf[0..len-1], then one dv=0 cycle carrying rx_er
    // (carrier extension, must be ignored). Pushes the expected beats.
    task automatic send_frame(input int len, input int rxer_at, input int exp_beats,
                              input bit exp_eof, input logic [2:0] exp_status);
        beat_t b;
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < len; i++) begin
            drive(1'b1, (i == rxer_at), fbuf[i]);
            if (i == 0) byte0_cyc = cyc;
            if (i < exp_beats) begin
                b.data = fbuf[i]; b.sof = (i == 0); b.eof = 1'b0; b.status = 3'd0;
                exp_q.push_back(b);
            end
        end
        drive(1'b0, 1'b1, 8'h00);
        dv_fall_cyc = cyc;
        if (exp_eof) begin
            b.data = 8'h00; b.sof = 1'b0; b.eof = 1'b1; b.status = exp_status;
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_eofs(input int n);
        for (int w = 0; w < 20 && eof_cnt < n; w++) @(posedge clk);
        repeat (2) @(posedge clk);
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_stat_ok"},  stat_frames_ok,  STATS ? 32'(exp_ok)  : 32'd0);
        check({tag, "_stat_bad"}, stat_frames_bad, STATS ? 32'(exp_bad) : 32'd0);
    endtask

    // Output monitor and scoreboard, sampled on the falling edge.
    beat_t       mon_e;
    logic [13:0] mon_got, mon_want;
    always @(negedge clk) begin
        if (out_valid || out_eof) begin
            if (sb_off) begin
                stray++;
            end else begin
                check("beat_excl", {30'd0, out_valid & out_eof, out_sof & ~out_valid}, 32'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL beat_unexpected: got valid=%0b eof=%0b data=%0h expected no beat",
                             out_valid, out_eof, out_data);
                end else begin
                    mon_e    = exp_q.pop_front();
                    mon_got  = {out_valid, out_eof, out_sof, out_valid ? out_data : 8'h00,
                                out_eof ? out_status : 3'd0};
                    mon_want = {~mon_e.eof, mon_e.eof, mon_e.sof, mon_e.data, mon_e.status};
                    check(mon_e.eof ? "eof_beat" : "data_beat", 32'(mon_got), 32'(mon_want));
                end
                if (out_eof) begin
                    eof_cnt++;
                    eof_cyc = cyc;
                end
                if (out_valid) begin
                    if (beat_cnt == 0) first_valid_cyc = cyc;
                    beat_cnt++;
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    vec_t vecs[9];

    initial begin
        vecs[0] = '{len: 64,   good_fcs: 1, flip: 0, rxer_at: -1, exp_beats: 60,   exp_eof: 1, exp_status: 3'd0};
        vecs[1] = '{len: 64,   good_fcs: 1, flip: 1, rxer_at: -1, exp_beats: 60,   exp_eof: 1, exp_status: 3'd1};
        vecs[2] = '{len: 60,   good_fcs: 1, flip: 0, rxer_at: -1, exp_beats: 56,   exp_eof: 1, exp_status: 3'd2};
        vecs[3] = '{len: 3,    good_fcs: 0, flip: 0, rxer_at: -1, exp_beats: 0,    exp_eof: 0, exp_status: 3'd0};
        vecs[4] = '{len: 5,    good_fcs: 1, flip: 0, rxer_at: -1, exp_beats: 1,    exp_eof: 1, exp_status: 3'd2};
        vecs[5] = '{len: 1518, good_fcs: 1, flip: 0, rxer_at: -1, exp_beats: 1514, exp_eof: 1, exp_status: 3'd0};
        vecs[6] = '{len: 1519, good_fcs: 1, flip: 0, rxer_at: -1, exp_beats: 1514, exp_eof: 1, exp_status: 3'd3};
        vecs[7] = '{len: 64,   good_fcs: 1, flip: 0, rxer_at: 20, exp_beats: 60,   exp_eof: 1, exp_status: 3'd4};
        vecs[8] = '{len: 65,   good_fcs: 1, flip: 0, rxer_at: -1, exp_beats: 61,   exp_eof: 1, exp_status: 3'd0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", {18'd0, out_valid, out_sof, out_eof, out_status, out_data}, 32'd0);
        check_stats("reset");
        arst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Table-driven frames.
        for (int v = 0; v < 9; v++) begin
            beat_cnt = 0;
            eof_cnt  = 0;
            build_frame(vecs[v].len, vecs[v].good_fcs, vecs[v].flip);
            send_frame(vecs[v].len, vecs[v].rxer_at, vecs[v].exp_beats, vecs[v].exp_eof, vecs[v].exp_status);
            wait_eofs(int'(vecs[v].exp_eof));
            if (!vecs[v].exp_eof)           exp_bad++;
            else if (vecs[v].exp_status == 0) exp_ok++;
            else                             exp_bad++;
            check($sformatf("vec%0d_beats", v), 32'(beat_cnt), 32'(vecs[v].exp_beats));
            check($sformatf("vec%0d_eofs", v),  32'(eof_cnt),  32'(vecs[v].exp_eof));
            if (vecs[v].exp_eof)
                check($sformatf("vec%0d_eof_lat", v), 32'(eof_cyc - dv_fall_cyc), 32'd1);
            if (vecs[v].exp_beats > 0)
                check($sformatf("vec%0d_first_lat", v), 32'(first_valid_cyc - byte0_cyc), 32'd5);
            check_stats($sformatf("vec%0d", v));
        end

        // Back-to-back frames with a single idle cycle between them.
        beat_cnt = 0;
        eof_cnt  = 0;
        build_frame(64, 1'b1, 1'b0);
        send_frame(64, -1, 60, 1'b1, 3'd0);
        build_frame(70, 1'b1, 1'b0);
        send_frame(70, -1, 66, 1'b1, 3'd0);
        wait_eofs(2);
        exp_ok += 2;
        check("b2b_beats", 32'(beat_cnt), 32'd126);
        check("b2b_eofs",  32'(eof_cnt),  32'd2);
        check_stats("b2b");

        // Bad preamble byte: dropped silently.
        beat_cnt = 0;
        eof_cnt  = 0;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h54);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'hD5);
        drive(1'b0, 1'b0, 8'h00);
        repeat (8) @(posedge clk);
        exp_bad++;
        check("badpre_beats", 32'(beat_cnt), 32'd0);
        check("badpre_eofs",  32'(eof_cnt),  32'd0);
        check_stats("badpre");

        // Reset mid-frame, released while rx_dv is still high.
        sb_off = 1'b1;
        build_frame(64, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 1'b0, fbuf[i]);
            if (i == 30) begin
                #1 arst_n = 1'b0;
                #1;
                check("rst_async_out", {18'd0, out_valid, out_sof, out_eof, out_status, out_data}, 32'd0);
                exp_ok  = 0;
                exp_bad = 0;
                check_stats("rst_async");
            end
            if (i == 33) begin
                arst_n = 1'b1;
                stray  = 0;
            end
        end
        drive(1'b0, 1'b0, 8'h00);
        check("rst_stray", 32'(stray), 32'd0);
        sb_off   = 1'b0;
        beat_cnt = 0;
        eof_cnt  = 0;
        build_frame(64, 1'b1, 1'b0);
        send_frame(64, -1, 60, 1'b1, 3'd0);
        wait_eofs(1);
        exp_ok++;
        check("rst_next_beats", 32'(beat_cnt), 32'd60);
        check("rst_next_eofs",  32'(eof_cnt),  32'd1);
        check_stats("rst_next");

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
